operand_bypass_stage: RTL and testbench

- Parametrised ID/EX operand stage for the pipelined MIPS core.
- Registers decoded source operands and destination info from ID.
- Resolves EX-stage forwarding per source from EX/MEM and MEM/WB, with EX/MEM taking priority.
- Detects load-use hazards, stalls ID for LOAD_USE_LAT cycles and inserts a bubble. Supports flush.

---
 rtl/bypass_pkg.sv | 26 ++
 rtl/fwd_select.sv | 47 ++++
 rtl/operand_bypass_stage.sv | 193 +++++++++++++++++++
 tb/tb_operand_bypass_stage.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bypass_pkg.sv
// Shared types for the ID/EX operand bypass stage.
// Forward-select encodings, stall FSM states and stats counter helper.
package bypass_pkg;

  localparam logic [1:0] FWD_SEL_REG   = 2'b00;
  localparam logic [1:0] FWD_SEL_EXMEM = 2'b10;
  localparam logic [1:0] FWD_SEL_MEMWB = 2'b01;

  localparam int STAT_W = 16;
  localparam int LAT_W  = 3;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } bypassState_e;

  function automatic logic [STAT_W-1:0] satAdd(
    input logic [STAT_W-1:0] a,
    input logic [STAT_W-1:0] b
  );
    logic [STAT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[STAT_W] ? '1 : s[STAT_W-1:0];
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Per-source forwarding: compare against EX/MEM and MEM/WB, pick, mux.
// EX/MEM has priority; register 0 is never forwarded.
module fwd_select
  import bypass_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int AW     = 5
) (
  input  logic              exValid,
  input  logic              srcUsed,
  input  logic [AW-1:0]     srcAddr,
  input  logic [DATA_W-1:0] regData,
  input  logic              exmemWrEn,
  input  logic [AW-1:0]     exmemRd,
  input  logic [DATA_W-1:0] exmemResult,
  input  logic              memwbWrEn,
  input  logic [AW-1:0]     memwbRd,
  input  logic [DATA_W-1:0] memwbResult,
  output logic [1:0]        sel,
  output logic [DATA_W-1:0] operand
);

  logic live;
  logic exHit;
  logic wbHit;

  assign live  = exValid & srcUsed & (srcAddr != '0);
  assign exHit = live & exmemWrEn & (exmemRd == srcAddr);
  assign wbHit = live & memwbWrEn & (memwbRd == srcAddr) & ~exHit;

  always_comb begin
    sel     = FWD_SEL_REG;
    operand = regData;
    unique case (1'b1)
      exHit: begin
        sel     = FWD_SEL_EXMEM;
        operand = exmemResult;
      end
      wbHit: begin
        sel     = FWD_SEL_MEMWB;
        operand = memwbResult;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/operand_bypass_stage.sv
// ID/EX operand register with forwarding and load-use stall control.
// Optional stall/forward counters under `BYPASS_STATS_EN.
module operand_bypass_stage
  import bypass_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int AW           = 5,
  parameter int NUM_SRC      = 2,
  parameter int LOAD_USE_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [NUM_SRC*AW-1:0]     id_src_addr,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic [NUM_SRC*DATA_W-1:0] id_src_data,
  input  logic [AW-1:0]             id_rd,
  input  logic                      id_wr_en,
  input  logic                      id_is_load,
  input  logic                      flush,
  input  logic                      exmem_wr_en,
  input  logic [AW-1:0]             exmem_rd,
  input  logic [DATA_W-1:0]         exmem_result,
  input  logic                      memwb_wr_en,
  input  logic [AW-1:0]             memwb_rd,
  input  logic [DATA_W-1:0]         memwb_result,
  output logic                      stall,
  output logic                      ex_valid,
  output logic [AW-1:0]             ex_rd,
  output logic                      ex_wr_en,
  output logic                      ex_is_load,
  output logic [NUM_SRC*2-1:0]      ex_fwd_sel,
  output logic [NUM_SRC*DATA_W-1:0] ex_operand
`ifdef BYPASS_STATS_EN
  ,
  output logic [STAT_W-1:0]         stall_cycles,
  output logic [STAT_W-1:0]         fwd_events
`endif
);

  bypassState_e state, stNext;
  logic [LAT_W-1:0] cnt, cntNext;

  logic                      exValid;
  logic [AW-1:0]             exRd;
  logic                      exWrEn;
  logic                      exIsLoad;
  logic [NUM_SRC*AW-1:0]     exSrcAddr;
  logic [NUM_SRC-1:0]        exSrcUsed;
  logic [NUM_SRC*DATA_W-1:0] exSrcData;

  logic srcHit;
  logic hz;
  logic bubble;
  logic killEx;

  always_comb begin
    srcHit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_src_used[i] && (id_src_addr[i*AW +: AW] == exRd))
        srcHit = 1'b1;
    end
  end

  assign hz = exValid & exIsLoad & exWrEn & (exRd != '0)
            & id_valid & srcHit;

  // Flush overrides everything, including a stall in progress.
  always_comb begin
    stNext  = state;
    cntNext = cnt;
    stall   = 1'b0;
    bubble  = 1'b0;
    if (flush) begin
      stNext  = ST_RUN;
      cntNext = '0;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (hz) begin
            stall  = 1'b1;
            bubble = 1'b1;
            if (LOAD_USE_LAT > 1) begin
              stNext  = ST_STALL;
              cntNext = LAT_W'(LOAD_USE_LAT - 1);
            end
          end
        end
        ST_STALL: begin
          stall   = 1'b1;
          bubble  = 1'b1;
          cntNext = cnt - LAT_W'(1);
          if (cnt == LAT_W'(1))
            stNext = ST_RUN;
        end
        default: begin
          stNext  = ST_RUN;
          cntNext = '0;
        end
      endcase
    end
  end

  assign killEx = flush | bubble;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      cnt       <= '0;
      exValid   <= 1'b0;
      exRd      <= '0;
      exWrEn    <= 1'b0;
      exIsLoad  <= 1'b0;
      exSrcAddr <= '0;
      exSrcUsed <= '0;
      exSrcData <= '0;
    end else begin
      state <= stNext;
      cnt   <= cntNext;
      if (killEx) begin
        exValid  <= 1'b0;
        exWrEn   <= 1'b0;
        exIsLoad <= 1'b0;
      end else begin
        exValid <= id_valid;
        if (id_valid) begin
          exRd      <= id_rd;
          exWrEn    <= id_wr_en;
          exIsLoad  <= id_is_load;
          exSrcAddr <= id_src_addr;
          exSrcUsed <= id_src_used;
          exSrcData <= id_src_data;
        end else begin
          exWrEn   <= 1'b0;
          exIsLoad <= 1'b0;
        end
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_SRC; g++) begin : gSrc
      fwd_select #(
        .DATA_W(DATA_W),
        .AW    (AW)
      ) uFwd (
        .exValid    (exValid),
        .srcUsed    (exSrcUsed[g]),
        .srcAddr    (exSrcAddr[g*AW +: AW]),
        .regData    (exSrcData[g*DATA_W +: DATA_W]),
        .exmemWrEn  (exmem_wr_en),
        .exmemRd    (exmem_rd),
        .exmemResult(exmem_result),
        .memwbWrEn  (memwb_wr_en),
        .memwbRd    (memwb_rd),
        .memwbResult(memwb_result),
        .sel        (ex_fwd_sel[g*2 +: 2]),
        .operand    (ex_operand[g*DATA_W +: DATA_W])
      );
    end
  endgenerate

  assign ex_valid   = exValid;
  assign ex_rd      = exRd;
  assign ex_wr_en   = exWrEn;
  assign ex_is_load = exIsLoad;

`ifdef BYPASS_STATS_EN
  logic [STAT_W-1:0] fwdCount;

  always_comb begin
    fwdCount = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (ex_fwd_sel[i*2 +: 2] != FWD_SEL_REG)
        fwdCount = fwdCount + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      fwd_events   <= '0;
    end else begin
      if (stall)
        stall_cycles <= satAdd(stall_cycles, STAT_W'(1));
      if (exValid)
        fwd_events <= satAdd(fwd_events, fwdCount);
    end
  end
`endif

endmodule

// File: tb/tb_operand_bypass_stage.sv
// Directed bench for operand_bypass_stage (LOAD_USE_LAT 1 and 3).
// Stats checks run only when BYPASS_STATS_EN is defined.
module tb_operand_bypass_stage;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NS = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic id_valid;
  logic [NS*AW-1:0] id_src_addr;
  logic [NS-1:0] id_src_used;
  logic [NS*DW-1:0] id_src_data;
  logic [AW-1:0] id_rd;
  logic id_wr_en;
  logic id_is_load;
  logic flush;
  logic exmem_wr_en;
  logic [AW-1:0] exmem_rd;
  logic [DW-1:0] exmem_result;
  logic memwb_wr_en;
  logic [AW-1:0] memwb_rd;
  logic [DW-1:0] memwb_result;

  logic stall1, exValid1, exWrEn1, exIsLoad1;
  logic [AW-1:0] exRd1;
  logic [NS*2-1:0] exFwdSel1;
  logic [NS*DW-1:0] exOperand1;

  logic stall3, exValid3, exWrEn3, exIsLoad3;
  logic [AW-1:0] exRd3;
  logic [NS*2-1:0] exFwdSel3;
  logic [NS*DW-1:0] exOperand3;

`ifdef BYPASS_STATS_EN
  logic [15:0] stallCycles1, fwdEvents1;
  logic [15:0] stallCycles3, fwdEvents3;
  logic [15:0] stallCycles7, fwdEvents7;
  logic stall7, exValid7, exWrEn7, exIsLoad7;
  logic [AW-1:0] exRd7;
  logic [NS*2-1:0] exFwdSel7;
  logic [NS*DW-1:0] exOperand7;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  operand_bypass_stage #(
    .DATA_W(DW), .AW(AW), .NUM_SRC(NS), .LOAD_USE_LAT(1)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_src_addr(id_src_addr), .id_src_used(id_src_used),
    .id_src_data(id_src_data), .id_rd(id_rd),
    .id_wr_en(id_wr_en), .id_is_load(id_is_load), .flush(flush),
    .exmem_wr_en(exmem_wr_en), .exmem_rd(exmem_rd),
    .exmem_result(exmem_result), .memwb_wr_en(memwb_wr_en),
    .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .stall(stall1), .ex_valid(exValid1), .ex_rd(exRd1),
    .ex_wr_en(exWrEn1), .ex_is_load(exIsLoad1),
    .ex_fwd_sel(exFwdSel1), .ex_operand(exOperand1)
`ifdef BYPASS_STATS_EN
    , .stall_cycles(stallCycles1), .fwd_events(fwdEvents1)
`endif
  );

  operand_bypass_stage #(
    .DATA_W(DW), .AW(AW), .NUM_SRC(NS), .LOAD_USE_LAT(3)
  ) u3 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_src_addr(id_src_addr), .id_src_used(id_src_used),
    .id_src_data(id_src_data), .id_rd(id_rd),
    .id_wr_en(id_wr_en), .id_is_load(id_is_load), .flush(flush),
    .exmem_wr_en(exmem_wr_en), .exmem_rd(exmem_rd),
    .exmem_result(exmem_result), .memwb_wr_en(memwb_wr_en),
    .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .stall(stall3), .ex_valid(exValid3), .ex_rd(exRd3),
    .ex_wr_en(exWrEn3), .ex_is_load(exIsLoad3),
    .ex_fwd_sel(exFwdSel3), .ex_operand(exOperand3)
`ifdef BYPASS_STATS_EN
    , .stall_cycles(stallCycles3), .fwd_events(fwdEvents3)
`endif
  );

`ifdef BYPASS_STATS_EN
  operand_bypass_stage #(
    .DATA_W(DW), .AW(AW), .NUM_SRC(NS), .LOAD_USE_LAT(7)
  ) u7 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_src_addr(id_src_addr), .id_src_used(id_src_used),
    .id_src_data(id_src_data), .id_rd(id_rd),
    .id_wr_en(id_wr_en), .id_is_load(id_is_load), .flush(flush),
    .exmem_wr_en(exmem_wr_en), .exmem_rd(exmem_rd),
    .exmem_result(exmem_result), .memwb_wr_en(memwb_wr_en),
    .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .stall(stall7), .ex_valid(exValid7), .ex_rd(exRd7),
    .ex_wr_en(exWrEn7), .ex_is_load(exIsLoad7),
    .ex_fwd_sel(exFwdSel7), .ex_operand(exOperand7),
    .stall_cycles(stallCycles7), .fwd_events(fwdEvents7)
  );
`endif

  task automatic checkEq(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearIn();
    id_valid = 0; id_src_addr = '0; id_src_used = '0;
    id_src_data = '0; id_rd = '0; id_wr_en = 0;
    id_is_load = 0; flush = 0;
    exmem_wr_en = 0; exmem_rd = '0; exmem_result = '0;
    memwb_wr_en = 0; memwb_rd = '0; memwb_result = '0;
  endtask

  task automatic doReset();
    clearIn();
    rst_n = 0;
    #2;
    rst_n = 1;
  endtask

  task automatic setId(input logic v, input logic [AW-1:0] a0,
                       input logic [AW-1:0] a1, input logic [1:0] used,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       input logic [AW-1:0] rd, input logic wr,
                       input logic ld);
    id_valid = v; id_src_addr = {a1, a0}; id_src_used = used;
    id_src_data = {d1, d0}; id_rd = rd; id_wr_en = wr;
    id_is_load = ld;
  endtask

  // lw r7 <- (r1), and a consumer of r7 writing r8
  task automatic idLoad();
    setId(1, 5'd1, 5'd0, 2'b01, 32'h0, 32'h0, 5'd7, 1, 1);
  endtask

  task automatic idDep();
    setId(1, 5'd7, 5'd2, 2'b11, 32'h70, 32'h22, 5'd8, 1, 0);
  endtask

  initial begin
    clearIn();
    rst_n = 0;
    #3;
    checkEq("rst_valid", exValid1, 0);
    checkEq("rst_stall", stall1, 0);
    checkEq("rst_rd", exRd1, 0);
    checkEq("rst_wr", exWrEn1, 0);
    checkEq("rst_ld", exIsLoad3, 0);
    checkEq("rst_op", exOperand1, 0);
    tick();
    rst_n = 1;

    // EX/MEM forward of r3
    setId(1, 5'd3, 5'd4, 2'b11, 32'h11, 32'h22, 5'd6, 1, 0);
    tick();
    id_valid = 0;
    exmem_wr_en = 1; exmem_rd = 5'd3; exmem_result = 32'h1234;
    #1;
    checkEq("exm_valid", exValid1, 1);
    checkEq("exm_rd", exRd1, 6);
    checkEq("exm_sel", exFwdSel1, 4'b0010);
    checkEq("exm_op0", exOperand1[31:0], 32'h1234);
    checkEq("exm_op1", exOperand1[63:32], 32'h22);

    // both stages write r5: EX/MEM wins
    setId(1, 5'd5, 5'd0, 2'b11, 32'h55, 32'h77, 5'd8, 1, 0);
    tick();
    id_valid = 0;
    exmem_wr_en = 1; exmem_rd = 5'd5; exmem_result = 32'hAAAA;
    memwb_wr_en = 1; memwb_rd = 5'd5; memwb_result = 32'hBBBB;
    #1;
    checkEq("dbl_sel", exFwdSel1, 4'b0010);
    checkEq("dbl_op0", exOperand1[31:0], 32'hAAAA);
    checkEq("dbl_op1", exOperand1[63:32], 32'h77);
    exmem_rd = 5'd0; memwb_rd = 5'd0;
    #1;
    checkEq("rd0_sel", exFwdSel1, 4'b0000);
    checkEq("rd0_op0", exOperand1[31:0], 32'h55);
    exmem_rd = 5'd5; exmem_wr_en = 0; memwb_rd = 5'd5;
    #1;
    checkEq("wb_sel", exFwdSel1, 4'b0001);
    checkEq("wb_op0", exOperand1[31:0], 32'hBBBB);

    // unused source never forwards
    setId(1, 5'd9, 5'd9, 2'b01, 32'h1, 32'h2, 5'd3, 1, 0);
    tick();
    id_valid = 0;
    exmem_wr_en = 1; exmem_rd = 5'd9; exmem_result = 32'h99;
    memwb_wr_en = 0;
    #1;
    checkEq("unused_sel", exFwdSel1, 4'b0010);
    checkEq("unused_op1", exOperand1[63:32], 32'h2);

    // source r0 with writers targeting r0
    setId(1, 5'd0, 5'd9, 2'b11, 32'hDEAD, 32'h1, 5'd3, 1, 0);
    tick();
    id_valid = 0;
    exmem_wr_en = 1; exmem_rd = 5'd0; exmem_result = 32'h99;
    memwb_wr_en = 1; memwb_rd = 5'd9; memwb_result = 32'hBEEF;
    #1;
    checkEq("src0_sel", exFwdSel1, 4'b0100);
    checkEq("src0_op0", exOperand1[31:0], 32'hDEAD);
    checkEq("src0_op1", exOperand1[63:32], 32'hBEEF);

    // load-use, one stall cycle
    doReset();
    idLoad();
    tick();
    idDep();
    #1;
    checkEq("lu1_isld", exIsLoad1, 1);
    checkEq("lu1_stall", stall1, 1);
    tick();
    checkEq("lu1_bub_v", exValid1, 0);
    checkEq("lu1_bub_wr", exWrEn1, 0);
    checkEq("lu1_nostall", stall1, 0);
    tick();
    id_valid = 0;
    memwb_wr_en = 1; memwb_rd = 5'd7; memwb_result = 32'hCAFE;
    #1;
    checkEq("lu1_valid", exValid1, 1);
    checkEq("lu1_rd", exRd1, 8);
    checkEq("lu1_sel", exFwdSel1, 4'b0001);
    checkEq("lu1_op0", exOperand1[31:0], 32'hCAFE);

    // load-use, three stall cycles
    doReset();
    idLoad();
    tick();
    idDep();
    #1;
    checkEq("lu3_st0", stall3, 1);
    tick();
    checkEq("lu3_st1", stall3, 1);
    checkEq("lu3_bub1", exValid3, 0);
    tick();
    checkEq("lu3_st2", stall3, 1);
    checkEq("lu3_bub2", exValid3, 0);
    tick();
    checkEq("lu3_st3", stall3, 0);
    checkEq("lu3_bub3", exValid3, 0);
    tick();
    checkEq("lu3_valid", exValid3, 1);
    checkEq("lu3_rd", exRd3, 8);

    // flush in the hazard cycle
    doReset();
    idLoad();
    tick();
    idDep();
    flush = 1;
    #1;
    checkEq("flz_stall3", stall3, 0);
    checkEq("flz_stall1", stall1, 0);
    tick();
    flush = 0;
    #1;
    checkEq("flz_valid", exValid3, 0);
    checkEq("flz_nostall", stall3, 0);
    tick();
    checkEq("flz_latch", exValid3, 1);

    // flush while in STALL
    doReset();
    idLoad();
    tick();
    idDep();
    tick();
    flush = 1;
    #1;
    checkEq("fls_stall", stall3, 0);
    tick();
    flush = 0;
    #1;
    checkEq("fls_valid", exValid3, 0);
    checkEq("fls_run", stall3, 0);
    tick();
    checkEq("fls_latch", exValid3, 1);

    // async reset during STALL
    doReset();
    idLoad();
    tick();
    idDep();
    tick();
    checkEq("rms_pre", stall3, 1);
    rst_n = 0;
    #1;
    checkEq("rms_stall", stall3, 0);
    checkEq("rms_valid", exValid3, 0);
    checkEq("rms_rd", exRd3, 0);
    checkEq("rms_op", exOperand3, 0);
    #2;
    rst_n = 1;
    tick();
    checkEq("rms_latch", exValid3, 1);
    checkEq("rms_run", stall3, 0);

`ifdef BYPASS_STATS_EN
    doReset();
    setId(1, 5'd3, 5'd4, 2'b11, 32'h0, 32'h0, 5'd6, 1, 0);
    tick();
    exmem_wr_en = 1; exmem_rd = 5'd3;
    memwb_wr_en = 1; memwb_rd = 5'd4;
    setId(1, 5'd1, 5'd0, 2'b00, 32'h0, 32'h0, 5'd7, 1, 1);
    tick();
    exmem_wr_en = 0; memwb_wr_en = 0;
    idDep();
    repeat (3) tick();
    checkEq("st_fwd", fwdEvents3, 16'd2);
    checkEq("st_stall", stallCycles3, 16'd3);

    doReset();
    setId(1, 5'd7, 5'd0, 2'b01, 32'h0, 32'h0, 5'd7, 1, 1);
    repeat (76000) tick();
    checkEq("st_sat", stallCycles7, 16'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
